// File: rtl/mm2s_burst_reader.sv
// mm2s_burst_reader
// MM2S read channel: splits one (address, beat count) command into AXI4 INCR
// bursts of at most MAX_BURST beats that never cross a 4 KB page, keeps up to
// MAX_OUTSTANDING bursts in flight and streams the read data out on AXI4-Stream.
// tlast marks only the final beat of the whole command.
// Optional build macro DMA_RD_SKID_EN: inserts a 2-entry skid buffer between
// R and AXIS with a registered rready (one extra cycle of latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a command, cmd_ready_o high
// ST_ISSUE| cutting the command into bursts and issuing them on AR
// ST_WAIT | all ARs issued, draining outstanding bursts until last rlast
// ST_DONE | one-cycle done_o pulse, then back to ST_IDLE

module mm2s_burst_reader #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 24,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_beats_i,

  output logic [ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
  output logic [7:0]            m_mm2s_axi_arlen,
  output logic [2:0]            m_mm2s_axi_arsize,
  output logic [1:0]            m_mm2s_axi_arburst,
  output logic [3:0]            m_mm2s_axi_arcache,
  output logic [2:0]            m_mm2s_axi_arprot,
  output logic                  m_mm2s_axi_arvalid,
  input  logic                  m_mm2s_axi_arready,

  input  logic [DATA_WIDTH-1:0] m_mm2s_axi_rdata,
  input  logic [1:0]            m_mm2s_axi_rresp,
  input  logic                  m_mm2s_axi_rlast,
  input  logic                  m_mm2s_axi_rvalid,
  output logic                  m_mm2s_axi_rready,

  output logic [DATA_WIDTH-1:0] m_mm2s_axis_tdata,
  output logic                  m_mm2s_axis_tvalid,
  output logic                  m_mm2s_axis_tlast,
  input  logic                  m_mm2s_axis_tready,

  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  total_q;
  logic [LEN_WIDTH-1:0]  rx_cnt_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [8:0]            burst_len_q;
  logic                  err_q;

  logic [12:0]           page_beats;
  logic [CW-1:0]         len_w;
  logic [8:0]            burst_len_d;

  logic                  cmd_fire;
  logic                  ar_fire;
  logic                  ar_raise;
  logic                  r_fire;
  logic                  rlast_fire;
  logic                  tlast_raw;
  logic                  unused_rresp0;

  assign cmd_ready_o   = (state_q == ST_IDLE) && !m_axi_areset;
  assign cmd_fire      = cmd_valid_i && cmd_ready_o;
  assign ar_fire       = arvalid_q && m_mm2s_axi_arready;
  assign r_fire        = m_mm2s_axi_rvalid && m_mm2s_axi_rready;
  assign rlast_fire    = r_fire && m_mm2s_axi_rlast;
  assign tlast_raw     = (rx_cnt_q == (total_q - LEN_WIDTH'(1)));
  assign unused_rresp0 = m_mm2s_axi_rresp[0];

  // A new AR is only prepared while no AR is pending and a slot is free.
  assign ar_raise = (state_q == ST_ISSUE) && !arvalid_q &&
                    (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                    (remaining_q != '0);

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

  assign m_mm2s_axi_araddr  = araddr_q;
  assign m_mm2s_axi_arlen   = arlen_q;
  assign m_mm2s_axi_arvalid = arvalid_q;
  assign m_mm2s_axi_arsize  = 3'(SIZE);
  assign m_mm2s_axi_arburst = 2'b01;
  assign m_mm2s_axi_arcache = 4'b0011;
  assign m_mm2s_axi_arprot  = 3'b000;

  // Next burst length: smallest of beats left, MAX_BURST and beats to the 4 KB page end.
  always_comb begin
    page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
    len_w      = CW'(MAX_BURST);
    if (CW'(remaining_q) < len_w) len_w = CW'(remaining_q);
    if (CW'(page_beats) < len_w)  len_w = CW'(page_beats);
    burst_len_d = 9'(len_w);
  end

  // State register.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_fire) state_d = (cmd_beats_i == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (ar_fire && (remaining_q == LEN_WIDTH'(burst_len_q))) state_d = ST_WAIT;
      ST_WAIT:  if (outstanding_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command capture and address/remaining bookkeeping advanced on each AR handshake.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
    end else if (cmd_fire) begin
      addr_q      <= cmd_addr_i & ~ADDR_WIDTH'(BYTES - 1);
      remaining_q <= cmd_beats_i;
      total_q     <= cmd_beats_i;
    end else if (ar_fire) begin
      addr_q      <= addr_q + (ADDR_WIDTH'(burst_len_q) << SIZE);
      remaining_q <= remaining_q - LEN_WIDTH'(burst_len_q);
    end
  end

  // AR channel: fields are latched when arvalid rises and held until arready.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      burst_len_q <= '0;
    end else if (ar_raise) begin
      arvalid_q   <= 1'b1;
      araddr_q    <= addr_q;
      arlen_q     <= 8'(burst_len_d - 9'd1);
      burst_len_q <= burst_len_d;
    end else if (ar_fire) begin
      arvalid_q   <= 1'b0;
    end
  end

  // Bursts in flight: up on AR handshake, down on the rlast beat handshake.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      outstanding_q <= '0;
    end else begin
      case ({ar_fire, rlast_fire})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Received beat counter and sticky response error (cleared by a new command).
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      rx_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (cmd_fire) begin
      rx_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (r_fire) begin
      rx_cnt_q <= rx_cnt_q + LEN_WIDTH'(1);
      if (m_mm2s_axi_rresp[1]) err_q <= 1'b1;
    end
  end

`ifdef DMA_RD_SKID_EN
  logic [DATA_WIDTH-1:0] skid_data_q [2];
  logic [1:0]            skid_last_q;
  logic                  skid_wr_q;
  logic                  skid_rd_q;
  logic [1:0]            skid_cnt_q;
  logic [1:0]            skid_cnt_d;
  logic                  rready_q;
  logic                  skid_push;
  logic                  skid_pop;

  assign skid_push          = m_mm2s_axi_rvalid && rready_q;
  assign skid_pop           = m_mm2s_axis_tvalid && m_mm2s_axis_tready;
  assign m_mm2s_axi_rready  = rready_q;
  assign m_mm2s_axis_tvalid = (skid_cnt_q != 2'd0);
  assign m_mm2s_axis_tdata  = skid_data_q[skid_rd_q];
  assign m_mm2s_axis_tlast  = skid_last_q[skid_rd_q];

  // Occupancy after this cycle's push/pop; rready is registered from it.
  always_comb begin
    skid_cnt_d = skid_cnt_q;
    if (skid_push && !skid_pop)      skid_cnt_d = skid_cnt_q + 2'd1;
    else if (!skid_push && skid_pop) skid_cnt_d = skid_cnt_q - 2'd1;
  end

  // Skid buffer pointers, occupancy, last flags and registered rready.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      skid_wr_q   <= 1'b0;
      skid_rd_q   <= 1'b0;
      skid_cnt_q  <= 2'd0;
      skid_last_q <= 2'b00;
      rready_q    <= 1'b0;
    end else begin
      if (skid_push) begin
        skid_last_q[skid_wr_q] <= tlast_raw;
        skid_wr_q              <= ~skid_wr_q;
      end
      if (skid_pop) skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_d;
      rready_q   <= (skid_cnt_d != 2'd2);
    end
  end

  // Skid buffer data storage; contents are qualified by occupancy.
  always_ff @(posedge m_axi_aclk) begin
    if (skid_push) skid_data_q[skid_wr_q] <= m_mm2s_axi_rdata;
  end
`else
  assign m_mm2s_axi_rready  = m_mm2s_axis_tready;
  assign m_mm2s_axis_tvalid = m_mm2s_axi_rvalid;
  assign m_mm2s_axis_tdata  = m_mm2s_axi_rdata;
  assign m_mm2s_axis_tlast  = m_mm2s_axi_rvalid && tlast_raw;
`endif

endmodule

// File: tb/tb_mm2s_burst_reader.sv
// Testbench for mm2s_burst_reader: AXI read slave model plus AXIS sink, with
// expected ARs and beats queued at command time and popped on each handshake.
module tb_mm2s_burst_reader;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int LW = 24;
  localparam int MB = 16;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_beats = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b0;
  logic          busy, done, err;

  always #5 clk = ~clk;

  mm2s_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(areset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
    .m_mm2s_axi_araddr(araddr), .m_mm2s_axi_arlen(arlen), .m_mm2s_axi_arsize(arsize),
    .m_mm2s_axi_arburst(arburst), .m_mm2s_axi_arcache(arcache), .m_mm2s_axi_arprot(arprot),
    .m_mm2s_axi_arvalid(arvalid), .m_mm2s_axi_arready(arready),
    .m_mm2s_axi_rdata(rdata), .m_mm2s_axi_rresp(rresp), .m_mm2s_axi_rlast(rlast),
    .m_mm2s_axi_rvalid(rvalid), .m_mm2s_axi_rready(rready),
    .m_mm2s_axis_tdata(tdata), .m_mm2s_axis_tvalid(tvalid), .m_mm2s_axis_tlast(tlast),
    .m_mm2s_axis_tready(tready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [63:0] data; logic last; } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  ar_t   slave_q[$];

  int checks = 0;
  int errors = 0;

  bit r_hold = 0, t_rand = 0, ar_rand = 0;
  int cyc = 0, r_beat = 0, cmd_beat = 0, err_at = -1;
  int acc_cyc = 0, done_cyc = 0, done_cnt = 0, ar_cnt = 0, rlast_cnt = 0;
  int ar_at_first_rlast = 0, err_early = 0, err_missing = 0, ar_unstable = 0, bad_const = 0;
  bit arv_at_first_rlast = 0, ar_pending = 0;
  logic [31:0] prev_araddr = '0;
  logic [7:0]  prev_arlen = '0;

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {~a, a};
  endfunction

  // AXI read slave, AXIS sink and scoreboard: inputs driven at negedge, handshakes sampled 1 ns later.
  initial begin
    ar_t   a;
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (areset) begin
        slave_q.delete();
        r_beat = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
        arready = 0; tready = 0; ar_pending = 0;
      end else begin
        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        tready  = t_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (slave_q.size() > 0 && !r_hold) begin
          rvalid = 1;
          rdata  = mem_data(slave_q[0].addr + 32'(r_beat * 8));
          rlast  = (r_beat == int'(slave_q[0].len));
          rresp  = (cmd_beat == err_at) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 0; rlast = 0; rresp = 0;
        end
        #1;
        if (arvalid && ar_pending && (araddr !== prev_araddr || arlen !== prev_arlen)) ar_unstable++;
        ar_pending  = arvalid && !arready;
        prev_araddr = araddr;
        prev_arlen  = arlen;
        if (arvalid && (arburst !== 2'b01 || arsize !== 3'd3 || arcache !== 4'b0011 || arprot !== 3'd0))
          bad_const++;
        if (arvalid && arready) begin
          ar_cnt++;
          slave_q.push_back(ar_t'{araddr, arlen});
          checks++;
          if (exp_ar.size() == 0) begin
            errors++;
            $display("FAIL ar_unexpected: got addr=%h len=%0d, expected none", araddr, arlen);
          end else begin
            a = exp_ar.pop_front();
            if (araddr !== a.addr || arlen !== a.len) begin
              errors++;
              $display("FAIL ar: got addr=%h len=%0d, expected addr=%h len=%0d", araddr, arlen, a.addr, a.len);
            end
          end
        end
        if (rvalid && rready) begin
          if (err_at >= 0 && cmd_beat <= err_at && err) err_early++;
          if (err_at >= 0 && cmd_beat > err_at && !err) err_missing++;
          cmd_beat++;
          if (rlast) begin
            rlast_cnt++;
            if (rlast_cnt == 1) begin
              ar_at_first_rlast  = ar_cnt;
              arv_at_first_rlast = arvalid;
            end
            void'(slave_q.pop_front());
            r_beat = 0;
          end else begin
            r_beat++;
          end
        end
        if (tvalid && tready) begin
          checks++;
          if (exp_beat.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got data=%h last=%0b, expected none", tdata, tlast);
          end else begin
            e = exp_beat.pop_front();
            if (tdata !== e.data || tlast !== e.last) begin
              errors++;
              $display("FAIL beat: got data=%h last=%0b, expected data=%h last=%0b", tdata, tlast, e.data, e.last);
            end
          end
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (done) begin
          done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic clear_sb();
    exp_ar.delete();
    exp_beat.delete();
    cmd_beat = 0; rlast_cnt = 0; err_at = -1; ar_cnt = 0;
    err_early = 0; err_missing = 0; ar_unstable = 0; bad_const = 0;
  endtask

  task automatic expect_beats(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++)
      exp_beat.push_back(beat_t'{mem_data(a + 32'(i * 8)), (i == n - 1)});
  endtask

  task automatic send_cmd(input logic [31:0] a, input int n);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = a; cmd_beats = LW'(n);
    #2;
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got cmd_ready=0 after %0d cycles, expected 1", k);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, expected a pulse", k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({cmd_ready, arvalid, busy, done, err, tvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000", {cmd_ready, arvalid, busy, done, err, tvalid});
    end
    @(negedge clk);
    areset = 0;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got cmd_ready=%0b busy=%0b, expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_burst();
    int d0 = done_cnt;
    clear_sb();
    exp_ar.push_back(ar_t'{32'h1000, 8'd7});
    expect_beats(32'h1000, 8);
    send_cmd(32'h1000, 8);
    wait_done(d0);
    #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got busy=%0b after done, expected 0", busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL single_done_pulse: got %0d done cycles, expected 1", done_cnt - d0);
    end
    checks++;
    if (exp_beat.size() != 0 || exp_ar.size() != 0 || ar_cnt != 1) begin
      errors++;
      $display("FAIL single_complete: got beats_left=%0d ars_left=%0d ar_cnt=%0d, expected 0 0 1",
               exp_beat.size(), exp_ar.size(), ar_cnt);
    end
    checks++;
    if (bad_const != 0) begin
      errors++;
      $display("FAIL ar_constants: got %0d bad AR cycles, expected 0", bad_const);
    end
  endtask

  task automatic test_split();
    int d0 = done_cnt;
    clear_sb();
    exp_ar.push_back(ar_t'{32'h0000, 8'd15});
    exp_ar.push_back(ar_t'{32'h0080, 8'd15});
    exp_ar.push_back(ar_t'{32'h0100, 8'd7});
    expect_beats(32'h0, 40);
    send_cmd(32'h0, 40);
    wait_done(d0);
    checks++;
    if (exp_beat.size() != 0 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL split_complete: got beats_left=%0d ars_left=%0d, expected 0 0", exp_beat.size(), exp_ar.size());
    end
  endtask

  task automatic test_page_cross();
    int d0 = done_cnt;
    clear_sb();
    exp_ar.push_back(ar_t'{32'h0FE0, 8'd3});
    exp_ar.push_back(ar_t'{32'h1000, 8'd5});
    expect_beats(32'h0FE0, 10);
    send_cmd(32'h0FE0, 10);
    wait_done(d0);
    d0 = done_cnt;
    exp_ar.push_back(ar_t'{32'h2FF8, 8'd0});
    exp_ar.push_back(ar_t'{32'h3000, 8'd1});
    expect_beats(32'h2FF8, 3);
    send_cmd(32'h2FFD, 3);
    wait_done(d0);
    checks++;
    if (exp_beat.size() != 0 || exp_ar.size() != 0 || ar_cnt != 4) begin
      errors++;
      $display("FAIL page_complete: got beats_left=%0d ars_left=%0d ar_cnt=%0d, expected 0 0 4",
               exp_beat.size(), exp_ar.size(), ar_cnt);
    end
  endtask

  task automatic test_outstanding();
    int d0 = done_cnt;
    clear_sb();
    for (int i = 0; i < 4; i++) exp_ar.push_back(ar_t'{32'h4000 + 32'(i * 128), 8'd15});
    expect_beats(32'h4000, 64);
    r_hold = 1;
    send_cmd(32'h4000, 64);
    repeat (30) @(negedge clk);
    #2;
    checks++;
    if (ar_cnt != MO || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_hold: got ar_cnt=%0d arvalid=%0b, expected %0d 0", ar_cnt, arvalid, MO);
    end
    r_hold = 0;
    wait_done(d0);
    checks++;
    if (ar_at_first_rlast != MO || arv_at_first_rlast !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_first_rlast: got ar_cnt=%0d arvalid=%0b, expected %0d 0",
               ar_at_first_rlast, arv_at_first_rlast, MO);
    end
    checks++;
    if (ar_cnt != 4 || exp_beat.size() != 0) begin
      errors++;
      $display("FAIL outstanding_complete: got ar_cnt=%0d beats_left=%0d, expected 4 0", ar_cnt, exp_beat.size());
    end
  endtask

  task automatic test_backpressure_err();
    int d0 = done_cnt;
    clear_sb();
    exp_ar.push_back(ar_t'{32'h0FC0, 8'd7});
    exp_ar.push_back(ar_t'{32'h1000, 8'd15});
    exp_ar.push_back(ar_t'{32'h1080, 8'd12});
    expect_beats(32'h0FC0, 37);
    err_at = 4;
    t_rand = 1; ar_rand = 1;
    send_cmd(32'h0FC0, 37);
    wait_done(d0);
    t_rand = 0; ar_rand = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_beat.size() != 0 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL bp_complete: got beats_left=%0d ars_left=%0d, expected 0 0", exp_beat.size(), exp_ar.size());
    end
    checks++;
    if (err_early != 0 || err_missing != 0) begin
      errors++;
      $display("FAIL err_timing: got early=%0d missing=%0d, expected 0 0", err_early, err_missing);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got err_o=%0b after done, expected 1", err);
    end
    checks++;
    if (ar_unstable != 0) begin
      errors++;
      $display("FAIL ar_stable: got %0d changes while stalled, expected 0", ar_unstable);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    clear_sb();
    send_cmd(32'h3000, 0);
    #2;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err_o=%0b after accept, expected 0", err);
    end
    wait_done(d0);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cyc - acc_cyc != 1 || ar_cnt != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_len: got done_delay=%0d ar_cnt=%0d pulses=%0d, expected 1 0 1",
               done_cyc - acc_cyc, ar_cnt, done_cnt - d0);
    end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    int d0;
    clear_sb();
    for (int i = 0; i < 4; i++) exp_ar.push_back(ar_t'{32'h5000 + 32'(i * 128), 8'd15});
    expect_beats(32'h5000, 64);
    send_cmd(32'h5000, 64);
    while (cmd_beat < 10 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #2;
    areset = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({arvalid, busy, tvalid, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: got arvalid,busy,tvalid,done,err=%b, expected 00000", {arvalid, busy, tvalid, done, err});
    end
    repeat (2) @(negedge clk);
    areset = 0;
    clear_sb();
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    exp_ar.push_back(ar_t'{32'h6000, 8'd3});
    expect_beats(32'h6000, 4);
    send_cmd(32'h6000, 4);
    wait_done(d0);
    checks++;
    if (exp_beat.size() != 0 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL reset_recovery: got beats_left=%0d ars_left=%0d, expected 0 0", exp_beat.size(), exp_ar.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_split();
    test_page_cross();
    test_outstanding();
    test_backpressure_err();
    test_zero_len();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
